// File: rtl/intersection_phase_sched_if.sv
// Intersection phase scheduler bundle.
// Demand/preempt inputs and lamp outputs.
interface intersection_phase_sched_if;
  logic [3:0] req;
  logic       ped_req;
  logic [3:0] emg_req;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;
  logic       walk;
  logic [1:0] cur_phase;
  logic       preempt;

  modport master (
    output req, ped_req, emg_req,
    input  green, yellow, red, walk,
    input  cur_phase, preempt
  );

  modport slave (
    input  req, ped_req, emg_req,
    output green, yellow, red, walk,
    output cur_phase, preempt
  );
endinterface

// File: rtl/intersection_phase_sched.sv
// Four-approach intersection phase scheduler.
// Green/yellow/all-red cycling, ped walk, emergency preempt.
module intersection_phase_sched #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 6,
  parameter int TW        = 5
) (
  input logic clk,
  input logic reset,
  intersection_phase_sched_if.slave bus
);
  typedef enum logic [1:0] {
    S_ALLRED, S_GREEN, S_YELLOW, S_WALK
  } state_t;

  localparam logic [TW-1:0] AR_T = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] MG_T = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MX_T = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] Y_T  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] W_T  = TW'(WALK - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0]    cur_q, cur_d;
  logic [1:0]    rr_q, rr_d;
  logic          pre_q, pre_d;
  logic          ped_q, ped_d;
  logic [3:0]    grn_q, grn_d;
  logic [3:0]    yel_q, yel_d;
  logic [3:0]    red_q, red_d;
  logic          walk_q, walk_d;

  logic [1:0] emg_idx;
  logic [1:0] rr_idx;
  logic [1:0] cand;
  logic       rr_hit;
  logic       emg_any;
  logic       other;
  logic       g_exit;

  // Arbitration: lowest emergency index, round-robin vehicle pick.
  always_comb begin
    emg_any = |bus.emg_req;
    emg_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.emg_req[i]) emg_idx = 2'(i);
    end
    rr_hit = 1'b0;
    rr_idx = rr_q;
    cand   = rr_q;
    for (int i = 4; i >= 1; i--) begin
      cand = rr_q + 2'(i);
      if (bus.req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
    other = |(bus.req & ~(4'b0001 << cur_q));
  end

  // Phase sequencing and lamp decode of the next state.
  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == '1) ? tmr_q : tmr_q + TW'(1);
    cur_d   = cur_q;
    rr_d    = rr_q;
    pre_d   = pre_q;
    ped_d   = ped_q | bus.ped_req;
    g_exit  = 1'b0;
    unique case (state_q)
      S_ALLRED: begin
        if (tmr_q >= AR_T) begin
          tmr_d = AR_T;
          if (emg_any) begin
            state_d = S_GREEN;
            cur_d   = emg_idx;
            pre_d   = 1'b1;
            tmr_d   = '0;
          end else if (ped_q) begin
            state_d = S_WALK;
            ped_d   = bus.ped_req;
            tmr_d   = '0;
          end else if (rr_hit) begin
            state_d = S_GREEN;
            cur_d   = rr_idx;
            rr_d    = rr_idx;
            pre_d   = 1'b0;
            tmr_d   = '0;
          end
        end
      end
      S_GREEN: begin
        if (pre_q) begin
          g_exit = (tmr_q >= MG_T) &&
                   !bus.emg_req[cur_q];
        end else begin
          g_exit = emg_any || (tmr_q == MX_T) ||
                   ((tmr_q >= MG_T) &&
                    (!bus.req[cur_q] || other || ped_q));
        end
        if (g_exit) begin
          state_d = S_YELLOW;
          tmr_d   = '0;
        end
      end
      S_YELLOW: begin
        if (tmr_q == Y_T) begin
          state_d = S_ALLRED;
          pre_d   = 1'b0;
          tmr_d   = '0;
        end
      end
      S_WALK: begin
        if (tmr_q == W_T) begin
          state_d = S_ALLRED;
          tmr_d   = '0;
        end
      end
    endcase
    grn_d  = (state_d == S_GREEN) ?
             (4'b0001 << cur_d) : 4'b0000;
    yel_d  = (state_d == S_YELLOW) ?
             (4'b0001 << cur_d) : 4'b0000;
    red_d  = ~(grn_d | yel_d);
    walk_d = (state_d == S_WALK);
  end

  // State, timer, latches and registered lamps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ALLRED;
      tmr_q   <= '0;
      cur_q   <= 2'd0;
      rr_q    <= 2'd3;
      pre_q   <= 1'b0;
      ped_q   <= 1'b0;
      grn_q   <= 4'h0;
      yel_q   <= 4'h0;
      red_q   <= 4'hF;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      pre_q   <= pre_d;
      ped_q   <= ped_d;
      grn_q   <= grn_d;
      yel_q   <= yel_d;
      red_q   <= red_d;
      walk_q  <= walk_d;
    end
  end

  assign bus.green     = grn_q;
  assign bus.yellow    = yel_q;
  assign bus.red       = red_q;
  assign bus.walk      = walk_q;
  assign bus.cur_phase = cur_q;
  assign bus.preempt   = pre_q;
endmodule

// File: tb/tb_intersection_phase_sched.sv
// Directed bench for intersection_phase_sched.
// Hand-computed lamp sequences per scenario.
module tb_intersection_phase_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  intersection_phase_sched_if bus();

  intersection_phase_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {bus.preempt, bus.cur_phase, bus.walk,
            bus.red, bus.yellow, bus.green};
  endfunction

  task automatic exp_seq(input string tag, input int n,
                         input logic [3:0] g,
                         input logic [3:0] y,
                         input logic w,
                         input logic [1:0] cp,
                         input logic pre);
    logic [15:0] e;
    e = {pre, cp, w, ~(g | y), y, g};
    for (int k = 0; k < n; k++) begin
      check(tag, obs(), e);
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 4'h0;
    bus.ped_req = 1'b0;
    bus.emg_req = 4'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.req = 4'h0;
    bus.ped_req = 1'b0;
    bus.emg_req = 4'h0;

    // single approach, max green
    do_reset();
    bus.req = 4'b0001;
    exp_seq("rst_ar", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("g0_max", 10, 4'h1, 4'h0, 0, 2'd0, 0);
    exp_seq("y0", 3, 4'h0, 4'h1, 0, 2'd0, 0);
    exp_seq("ar0", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("g0_again", 1, 4'h1, 4'h0, 0, 2'd0, 0);

    // round-robin 0,1,3,0 at min green
    do_reset();
    bus.req = 4'b1011;
    exp_seq("rr_ar", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("rr_g0", 4, 4'h1, 4'h0, 0, 2'd0, 0);
    exp_seq("rr_y0", 3, 4'h0, 4'h1, 0, 2'd0, 0);
    exp_seq("rr_ar0", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("rr_g1", 4, 4'h2, 4'h0, 0, 2'd1, 0);
    exp_seq("rr_y1", 3, 4'h0, 4'h2, 0, 2'd1, 0);
    exp_seq("rr_ar1", 2, 4'h0, 4'h0, 0, 2'd1, 0);
    exp_seq("rr_g3", 4, 4'h8, 4'h0, 0, 2'd3, 0);
    exp_seq("rr_y3", 3, 4'h0, 4'h8, 0, 2'd3, 0);
    exp_seq("rr_ar3", 2, 4'h0, 4'h0, 0, 2'd3, 0);
    exp_seq("rr_g0b", 1, 4'h1, 4'h0, 0, 2'd0, 0);

    // pedestrian walk phase
    do_reset();
    bus.req = 4'b0100;
    exp_seq("pd_ar", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("pd_g2a", 1, 4'h4, 4'h0, 0, 2'd2, 0);
    bus.ped_req = 1'b1;
    exp_seq("pd_g2b", 1, 4'h4, 4'h0, 0, 2'd2, 0);
    bus.ped_req = 1'b0;
    exp_seq("pd_g2c", 2, 4'h4, 4'h0, 0, 2'd2, 0);
    exp_seq("pd_y2", 3, 4'h0, 4'h4, 0, 2'd2, 0);
    exp_seq("pd_ar2", 2, 4'h0, 4'h0, 0, 2'd2, 0);
    exp_seq("pd_walk", 6, 4'h0, 4'h0, 1, 2'd2, 0);
    exp_seq("pd_arw", 2, 4'h0, 4'h0, 0, 2'd2, 0);
    exp_seq("pd_g2d", 1, 4'h4, 4'h0, 0, 2'd2, 0);

    // emergency preemption
    do_reset();
    bus.req = 4'b0010;
    exp_seq("em_ar", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("em_g1a", 1, 4'h2, 4'h0, 0, 2'd1, 0);
    bus.emg_req = 4'b1000;
    exp_seq("em_g1b", 1, 4'h2, 4'h0, 0, 2'd1, 0);
    exp_seq("em_y1", 3, 4'h0, 4'h2, 0, 2'd1, 0);
    exp_seq("em_ar1", 2, 4'h0, 4'h0, 0, 2'd1, 0);
    exp_seq("em_g3", 14, 4'h8, 4'h0, 0, 2'd3, 1);
    bus.emg_req = 4'h0;
    exp_seq("em_g3end", 1, 4'h8, 4'h0, 0, 2'd3, 1);
    exp_seq("em_y3", 3, 4'h0, 4'h8, 0, 2'd3, 1);
    exp_seq("em_ar3", 2, 4'h0, 4'h0, 0, 2'd3, 0);
    exp_seq("em_g1c", 1, 4'h2, 4'h0, 0, 2'd1, 0);

    // idle, then one-cycle latency
    do_reset();
    exp_seq("idle", 50, 4'h0, 4'h0, 0, 2'd0, 0);
    bus.req = 4'b0100;
    exp_seq("idle_last", 1, 4'h0, 4'h0, 0, 2'd0, 0);
    bus.req = 4'h0;
    exp_seq("idle_g2", 4, 4'h4, 4'h0, 0, 2'd2, 0);
    exp_seq("idle_y2", 1, 4'h0, 4'h4, 0, 2'd2, 0);

    // reset during yellow with ped pending
    do_reset();
    bus.req = 4'b0010;
    exp_seq("rs_ar", 2, 4'h0, 4'h0, 0, 2'd0, 0);
    exp_seq("rs_g1a", 1, 4'h2, 4'h0, 0, 2'd1, 0);
    bus.ped_req = 1'b1;
    exp_seq("rs_g1b", 1, 4'h2, 4'h0, 0, 2'd1, 0);
    bus.ped_req = 1'b0;
    exp_seq("rs_g1c", 2, 4'h2, 4'h0, 0, 2'd1, 0);
    exp_seq("rs_y1", 1, 4'h0, 4'h2, 0, 2'd1, 0);
    reset = 1'b1;
    bus.req = 4'h0;
    tick();
    reset = 1'b0;
    exp_seq("rs_after", 12, 4'h0, 4'h0, 0, 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/intersection_phase_sched.md
# intersection_phase_sched

Four-approach intersection phase scheduler. It shares the intersection between vehicle demand on four approaches, a pedestrian crossing request and emergency-vehicle preemption. It sequences green → yellow → all-red phases with min/max green timing, round-robin fairness and a protected walk phase. Its lamp outputs drive the per-approach signal heads and the walk indicator.

## Interface
Parameters:
- MIN_GREEN, 4: minimum green length in cycles (≥1)
- MAX_GREEN, 10: maximum green length for normal (non-preempt) green (≥MIN_GREEN)
- YELLOW, 3: yellow length in cycles (≥1)
- ALL_RED, 2: minimum all-red clearance in cycles (≥1)
- WALK, 6: walk phase length in cycles (≥1)
- TW, 5: timer width; must hold max(MAX_GREEN, WALK) − 1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  4  vehicle demand per approach, level
- ped_req  in  1  pedestrian request; a single-cycle pulse is sufficient (latched internally)
- emg_req  in  4  emergency preemption per approach, level
- green  out  4  green lamps, at most one bit set
- yellow  out  4  yellow lamps, at most one bit set
- red  out  4  red lamps; always equals ~(green|yellow)
- walk  out  1  walk indicator
- cur_phase  out  2  index of the approach owning the current or most recent green
- preempt  out  1  high while the current green was granted by emergency

## Operation
- States: ALLRED, GREEN, YELLOW, WALKPH.
- All outputs are registered and change only on clock edges. Outputs are a Moore decode of the state, cur_phase and preempt.
- A timer clears on every state entry. A state of duration D occupies timer values 0..D−1.
- ped_pend is set by ped_req, cleared on entry to WALKPH, and set again by ped_req arriving during WALKPH.
- rr_last holds the last approach granted a normal green. Reset value is 3.
- ALLRED:
  - Lasts at least ALL_RED cycles.
  - Decision is made at timer ≥ ALL_RED−1. The timer saturates at ALL_RED−1.
  - Priority: emergency (lowest-index set emg_req bit; preempt=1) > ped_pend (→WALKPH) > vehicle round-robin.
  - Round-robin searches for the first set req bit starting at (rr_last+1) mod 4, and updates rr_last to the granted index.
  - With no demand, the block stays in ALLRED indefinitely.
- GREEN, normal (preempt=0): exit to YELLOW at the edge where any of the following holds:
  - emg_req has any bit set (truncates green regardless of timer);
  - timer == MAX_GREEN−1;
  - timer ≥ MIN_GREEN−1 and (req[cur]==0, or req has a set bit at another approach, or ped_pend).
- GREEN, preempt: exit to YELLOW at the edge where timer ≥ MIN_GREEN−1 and emg_req[cur]==0. MAX_GREEN does not apply. ped_req and vehicle demand are ignored.
- YELLOW: YELLOW cycles, then ALLRED. preempt clears on entry to ALLRED.
- WALKPH: all red, walk=1, for exactly WALK cycles, then ALLRED. Not truncated by emergency.
- Reset values: state ALLRED, timer 0, green=0, yellow=0, red=4'hF, walk=0, preempt=0, cur_phase=0, rr_last=3, ped_pend=0.

## Timing
- Decision latency: for demand visible at the edge where the ALLRED decision is made, green/walk is asserted immediately after that edge.
- When idle in ALLRED with the timer saturated, a req bit rising before edge e gives green after edge e. This is a 1-cycle latency.
- Green → yellow → allred transitions are single-edge. There is never a cycle with green and yellow both set, and never a green without a preceding ALLRED of ≥ALL_RED cycles.
- Simultaneous events at the ALLRED decision edge: emergency wins over ped, and ped wins over vehicles.
- ped_req and emg_req in the same cycle: the emergency is served and ped_pend is retained.
- Synchronous reset at any point: all outputs take their reset values at that edge, and the ped latch is cleared.

## Test plan
- Reset, then req=4'b0001 held → ALLRED for 2 cycles, then green[0] for 10 cycles, yellow[0] for 3, ALLRED for 2, then green[0] again with cur_phase=0.
- req=4'b1011 held → greens in order 0,1,3,0,… with each green lasting exactly 4 cycles; red never 4'hF for longer than 2 cycles.
- ped_req pulse at cycle 1 of green[2] (req[2] held) → green ends at 4 cycles, then yellow 3, ALLRED 2, walk=1 for 6 cycles with red=4'hF, ALLRED 2, then green[2].
- emg_req[3] high at cycle 1 of green[1], held 20 cycles → yellow[1] next edge, then ALLRED 2, then green[3] with preempt=1 until emg_req[3] drops. Yellow[3] follows on the next edge, and preempt=0 in the following ALLRED.
- No demand for 50 cycles → red=4'hF and walk=0 throughout. Then req[2] pulsed high → green[2] asserted one edge later.
- reset asserted during yellow[1] with ped_pend set → next edge: red=4'hF, yellow=0, walk=0, and no WALKPH follows without a new ped_req.
